// File: rtl/fact_pkg.sv
// Shared types and constants for the iterative factorial engine.
// Optional FACT_OVF_DETECT_EN build enables sticky overflow detection in fact_mul.
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned ACC_INIT = 1;

endpackage

// File: rtl/fact_mul.sv
// Combinational WIDTH x (WIDTH+1) multiplier producing a truncated product.
// With FACT_OVF_DETECT_EN the full product is formed and its upper bits flag overflow.
module fact_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH-1:0] p,
    output logic             ovf
);

`ifdef FACT_OVF_DETECT_EN
    logic [2*WIDTH:0] full_prod;

    always_comb begin
        full_prod = {{(WIDTH + 1){1'b0}}, a} * {{WIDTH{1'b0}}, b};
        p         = full_prod[WIDTH-1:0];
        ovf       = |full_prod[2*WIDTH:WIDTH];
    end
`else
    // Low WIDTH bits of a*b depend only on the low WIDTH bits of b.
    logic unused_b_msb;

    assign unused_b_msb = b[WIDTH];

    always_comb begin
        p   = a * b[WIDTH-1:0];
        ovf = 1'b0;
    end
`endif

endmodule

// File: rtl/fact_engine.sv
// Iterative n! engine: one multiply per cycle, valid/ready handshake on both sides.
// FACT_OVF_DETECT_EN enables the sticky ovf output; otherwise ovf stays 0.
module fact_engine
    import fact_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ACC_RST  = WIDTH'(ACC_INIT);
    localparam logic [WIDTH:0]   CNT_INIT = (WIDTH + 1)'(2);
    localparam logic [WIDTH:0]   CNT_ONE  = (WIDTH + 1)'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] prod;
    logic             mul_ovf;

    fact_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .a   (acc_q),
        .b   (cnt_q),
        .p   (prod),
        .ovf (mul_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            acc_q   <= ACC_RST;
            cnt_q   <= CNT_INIT;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d     = n;
                    acc_d   = ACC_RST;
                    cnt_d   = CNT_INIT;
                    ovf_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // cnt is one bit wider than n, so n = 2^WIDTH-1 still terminates.
                if (cnt_q > {1'b0, n_q}) begin
                    state_d = DONE;
                end else begin
                    acc_d = prod;
                    cnt_d = cnt_q + CNT_ONE;
                    ovf_d = ovf_q | mul_ovf;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = out_valid ? acc_q : '0;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_fact_engine.sv
// Self-checking bench for fact_engine: directed corner cases plus random operands.
module tb_fact_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, ovf, busy;
    logic [7:0] n8, result;

    logic        iv16, ir16, ov16, or16, ovf16, busy16;
    logic [15:0] n16, res16;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fact_engine #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .n(n8),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf), .busy(busy)
    );

    fact_engine #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .n(n16),
        .out_valid(ov16), .out_ready(or16), .result(res16), .ovf(ovf16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // True n! reduced mod 2^w, plus whether the exact value exceeds 2^w-1.
    task automatic model(input int w, input int nv, output logic [63:0] res, output logic big);
        longint exact = 1;
        longint lim   = (longint'(1) << w) - 1;
        res = 1;
        big = 1'b0;
        for (int i = 2; i <= nv; i++) begin
            res = (res * i) & lim;
            if (!big) begin
                exact = exact * i;
                if (exact > lim) big = 1'b1;
            end
        end
`ifndef FACT_OVF_DETECT_EN
        big = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int nv);
        int t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        check("ready_before_send", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        n8       = 8'(nv);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int nv);
        int          lat = 0;
        logic [63:0] er;
        logic        eo;
        model(8, nv, er, eo);
        while (!out_valid && lat < 600) begin
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'((nv < 1) ? 1 : nv));
        check("result", {56'd0, result}, er);
        check("ovf", {63'd0, ovf}, {63'd0, eo});
        check("busy_done", {63'd0, busy}, 64'd1);
        check("in_ready_done", {63'd0, in_ready}, 64'd0);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
        check("idle_result_zero", {56'd0, result}, 64'd0);
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        check("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int          a0, a1, nv, hold, lat;
        logic [63:0] er;
        logic        eo;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; n8 = '0;
        iv16 = 1'b0; or16 = 1'b1; n16 = '0;
        step();
        step();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", {56'd0, result}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        rst_n = 1'b1;
        step();
        check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

        // n=5 with consumer always ready
        out_ready = 1'b1;
        send(5);
        wait_done(5);
        handshake();

        // n=0 then n=1; in_valid held through the result handshake must not be taken early
        send(0);
        a0 = cyc;
        wait_done(0);
        in_valid  = 1'b1;
        n8        = 8'd1;
        out_ready = 1'b1;
        step();
        check("no_accept_on_handshake", {63'd0, busy}, 64'd0);
        check("ready_after_handshake", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a1 = cyc;
        check("accept_spacing", 64'(a1 - a0), 64'd3);
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        wait_done(1);
        handshake();

        // n=6: 720 mod 256, ovf depends on build
        send(6);
        wait_done(6);
        handshake();

        // n=4 with the consumer stalled; stray requests must be ignored
        send(4);
        wait_done(4);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            n8       = 8'd99;
            step();
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", {56'd0, result}, 64'd24);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        handshake();

        // n=255: counter must not wrap
        send(255);
        wait_done(255);
        handshake();

        // reset while CALC is in flight
        send(7);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_result", {56'd0, result}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        send(3);
        wait_done(3);
        handshake();

        // random operands with random consumer stalls
        for (int k = 0; k < 20; k++) begin
            nv   = int'($urandom_range(0, 12));
            hold = int'($urandom_range(0, 3));
            send(nv);
            wait_done(nv);
            model(8, nv, er, eo);
            for (int h = 0; h < hold; h++) begin
                step();
                check("rand_hold_result", {56'd0, result}, er);
            end
            handshake();
        end

        // WIDTH=16, n=8
        iv16 = 1'b1;
        n16  = 16'd8;
        step();
        iv16 = 1'b0;
        lat  = 0;
        while (!ov16 && lat < 100) begin
            step();
            lat++;
        end
        model(16, 8, er, eo);
        check("w16_latency", 64'(lat), 64'd8);
        check("w16_result", {48'd0, res16}, er);
        check("w16_ovf", {63'd0, ovf16}, {63'd0, eo});
        step();
        check("w16_idle", {63'd0, ir16}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fact_engine.md
FACT_ENGINE -- requirements
Module: fact_engine

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present on n.
REQ-005 in_ready  output  1  engine can accept a request.
REQ-006 n  input  WIDTH  operand, unsigned.
REQ-007 out_valid  output  1  result and ovf are valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 result  output  WIDTH  n! modulo 2^WIDTH.
REQ-010 ovf  output  1  true n! exceeded 2^WIDTH-1.
REQ-011 busy  output  1  high in CALC and DONE states.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC and DONE, and no others.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready, latch n, set acc=1, cnt=2, ovf=0, and go to CALC.
REQ-014 CALC, each cycle: if cnt>n_latched, go to DONE; else acc<=low WIDTH bits of acc*cnt, cnt<=cnt+1.
REQ-015 cnt SHALL be WIDTH+1 bits wide, so n=2^WIDTH-1 terminates without wrap-around.
REQ-016 Latency from the accept edge to out_valid high SHALL be max(n,1) cycles; n=0 and n=1 both give result=1.
REQ-017 DONE: out_valid=1; result and ovf SHALL stay stable until out_ready=1, then go to IDLE.
REQ-018 in_ready SHALL be 0 in CALC and DONE; in_valid is ignored there and the latched n is unaffected.
REQ-019 A new request SHALL NOT be accepted in the same cycle as the result handshake; the earliest accept is the cycle after.
REQ-020 result SHALL read 0 whenever out_valid=0.
REQ-021 The multiply SHALL be combinational: WIDTH x (WIDTH+1) bits, full-width product internally, truncated to WIDTH.

Reset
REQ-022 rst_n low, at any time including mid-CALC, SHALL asynchronously force IDLE, acc=1, cnt=2, ovf=0, out_valid=0, busy=0, result=0.
REQ-023 in_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-024 A request in flight when reset asserts SHALL be discarded, with no result produced.

Configuration
REQ-025 Macro FACT_OVF_DETECT_EN defined: ovf is sticky; it sets in any CALC step whose full product has nonzero bits above WIDTH-1.
REQ-026 Without FACT_OVF_DETECT_EN: ovf is tied to 0, and the upper product bits are neither computed nor compared.
REQ-027 Port list SHALL be identical in both builds.

Structure
REQ-028 Package fact_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the constant ACC_INIT=1.
REQ-029 Sub-module fact_mul SHALL contain the multiplier and its overflow flag, parameterised by WIDTH.
REQ-030 The FSM, counter and accumulator SHALL live in fact_engine; no other sub-modules.

Verification (WIDTH=8 unless stated)
REQ-031 n=5, out_ready=1 -> result=120, ovf=0, out_valid rises 5 cycles after accept.
REQ-032 n=0, then n=1 back-to-back -> result=1 each, latency 1 each, one idle cycle between accepts.
REQ-033 n=6 with FACT_OVF_DETECT_EN -> result=208 (720 mod 256), ovf=1; without the macro -> result=208, ovf=0.
REQ-034 n=4, out_ready held 0 for 10 cycles -> out_valid stays 1 and result=24 stays stable; in_valid pulses during the hold are ignored; IDLE on the first out_ready.
REQ-035 n=255 -> terminates after 255 cycles with no counter wrap, ovf=1; WIDTH=16, n=8 -> result=40320, ovf=0.
REQ-036 rst_n pulsed low 3 cycles after accepting n=7 -> immediate out_valid=0 and busy=0; next request n=3 -> result=6.
